direct_mapped_cache_controller: RTL

- Direct-mapped, write-back, write-allocate cache controller: the initiator side of the cache-to-memory request/response protocol.
- Accepts single-word CPU reads and writes. On a miss it writes back the dirty victim block, then fetches the new block from main memory using `mem_req`/`mem_data`.
- Sits between the CPU bench and `main_memory_model`.

---
 rtl/direct_mapped_cache_controller_pkg.sv | 63 ++++++
 rtl/direct_mapped_cache_controller_if.sv | 24 ++
 rtl/direct_mapped_cache_controller_store.sv | 40 ++++
 rtl/direct_mapped_cache_controller.sv | 130 +++++++++++++
 4 files changed

// File: rtl/direct_mapped_cache_controller_pkg.sv
// Shared types, field geometry and helpers for the direct-mapped write-back cache.
package cache_def;

    localparam int TAGMSB     = 31;
    localparam int TAGLSB     = 14;
    localparam int TAG_BITS   = TAGMSB - TAGLSB + 1;
    localparam int INDEX_BITS = 10;
    localparam int NUM_BLOCKS = 1 << INDEX_BITS;

    typedef logic [TAG_BITS-1:0]   cache_tag_bits_type;
    typedef logic [INDEX_BITS-1:0] cache_index_type;
    typedef logic [127:0]          cache_data_type;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        cache_tag_bits_type tag;
    } cache_tag_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]    addr;
        cache_data_type data;
        logic           rw;
        logic           valid;
    } mem_req_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE_TAG,
        WRITE_BACK,
        ALLOCATE
    } cache_state_type;

    function automatic logic [31:0] get_word(input cache_data_type blk, input logic [1:0] sel);
        return blk[{sel, 5'b0} +: 32];
    endfunction

    function automatic cache_data_type merge_word(input cache_data_type blk, input logic [1:0] sel,
                                                  input logic [31:0] word);
        cache_data_type res;
        res = blk;
        res[{sel, 5'b0} +: 32] = word;
        return res;
    endfunction

endpackage

// File: rtl/direct_mapped_cache_controller_if.sv
// CPU-side and memory-side buses of the cache controller; master is the controller's view.
interface direct_mapped_cache_controller_if;
    import cache_def::*;

    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    mem_req_type    mem_req;
    mem_data_type   mem_data;

    modport master (
        input  cpu_req,
        input  mem_data,
        output cpu_res,
        output mem_req
    );

    modport slave (
        output cpu_req,
        output mem_data,
        input  cpu_res,
        input  mem_req
    );

endinterface

// File: rtl/direct_mapped_cache_controller_store.sv
// Tag/state and data arrays: combinational read, synchronous write with separate enables.
module cache_tag_data_store
    import cache_def::*;
(
    input  logic            clk,
    input  logic            rst,
    input  cache_index_type i_index,
    input  logic            i_tag_we,
    input  cache_tag_type   i_tag_wdata,
    input  logic            i_data_we,
    input  cache_data_type  i_data_wdata,
    output cache_tag_type   o_tag,
    output cache_data_type  o_data
);

    cache_tag_type  r_tag_mem  [NUM_BLOCKS];
    cache_data_type r_data_mem [NUM_BLOCKS];

    assign o_tag  = r_tag_mem[i_index];
    assign o_data = r_data_mem[i_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_tag_mem[i].valid <= 1'b0;
                r_tag_mem[i].dirty <= 1'b0;
            end
        end else if (i_tag_we) begin
            r_tag_mem[i_index] <= i_tag_wdata;
        end
    end

    // NOTE: the data array has no reset; a block is only observed once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_data_we) begin
            r_data_mem[i_index] <= i_data_wdata;
        end
    end

endmodule

// File: rtl/direct_mapped_cache_controller.sv
// Direct-mapped write-back, write-allocate cache controller: FSM, request register, word select/merge.
module direct_mapped_cache_controller
    import cache_def::*;
(
    input  logic                               clk,
    input  logic                               rst,
    direct_mapped_cache_controller_if.master   io_bus
);

    cache_state_type    r_state;
    logic [31:2]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_rw;
    cache_tag_bits_type r_victim_tag;

    cache_tag_type      w_tag_rd;
    cache_tag_type      w_tag_wdata;
    cache_data_type     w_data_rd;
    cache_data_type     w_data_wdata;
    logic               w_tag_we;
    logic               w_data_we;
    logic               w_hit;
    cache_tag_bits_type w_req_tag;
    cache_index_type    w_index;
    logic [1:0]         w_word;
    cpu_result_type     w_cpu_res;
    mem_req_type        w_mem_req;

    assign w_req_tag = r_addr[TAGMSB:TAGLSB];
    assign w_index   = r_addr[TAGLSB-1:4];
    assign w_word    = r_addr[3:2];
    assign w_hit     = w_tag_rd.valid && (w_tag_rd.tag == w_req_tag);

    cache_tag_data_store u_store (
        .clk          (clk),
        .rst          (rst),
        .i_index      (w_index),
        .i_tag_we     (w_tag_we),
        .i_tag_wdata  (w_tag_wdata),
        .i_data_we    (w_data_we),
        .i_data_wdata (w_data_wdata),
        .o_tag        (w_tag_rd),
        .o_data       (w_data_rd)
    );

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        w_tag_we     = 1'b0;
        w_tag_wdata  = w_tag_rd;
        w_data_we    = 1'b0;
        w_data_wdata = w_data_rd;
        w_cpu_res    = '0;
        w_mem_req    = '0;
        case (r_state)
            COMPARE_TAG: begin
                if (w_hit) begin
                    w_cpu_res.ready = 1'b1;
                    if (r_rw) begin
                        w_data_we         = 1'b1;
                        w_data_wdata      = merge_word(w_data_rd, w_word, r_wdata);
                        w_tag_we          = 1'b1;
                        w_tag_wdata.dirty = 1'b1;
                    end else begin
                        w_cpu_res.data = get_word(w_data_rd, w_word);
                    end
                end else begin
                    // Dirty survives the tag rewrite so the victim decision and eviction stay intact.
                    w_tag_we    = 1'b1;
                    w_tag_wdata = '{valid: 1'b1, dirty: w_tag_rd.dirty, tag: w_req_tag};
                end
            end
            WRITE_BACK: begin
                w_mem_req = '{addr: {r_victim_tag, w_index, 4'h0}, data: w_data_rd,
                              rw: 1'b1, valid: !io_bus.mem_data.ready};
            end
            ALLOCATE: begin
                w_mem_req = '{addr: {w_req_tag, w_index, 4'h0}, data: '0,
                              rw: 1'b0, valid: !io_bus.mem_data.ready};
                if (io_bus.mem_data.ready) begin
                    w_data_we    = 1'b1;
                    w_data_wdata = io_bus.mem_data.data;
                    w_tag_we     = 1'b1;
                    w_tag_wdata  = '{valid: 1'b1, dirty: 1'b0, tag: w_req_tag};
                end
            end
            default: ;
        endcase
    end

    assign io_bus.cpu_res = w_cpu_res;
    assign io_bus.mem_req = w_mem_req;

    // NOTE: state and request registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rw         <= 1'b0;
            r_victim_tag <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.cpu_req.valid) begin
                        r_addr  <= io_bus.cpu_req.addr[31:2];
                        r_wdata <= io_bus.cpu_req.data;
                        r_rw    <= io_bus.cpu_req.rw;
                        r_state <= COMPARE_TAG;
                    end
                end
                COMPARE_TAG: begin
                    if (w_hit) begin
                        r_state <= IDLE;
                    end else begin
                        r_victim_tag <= w_tag_rd.tag;
                        r_state      <= (w_tag_rd.valid && w_tag_rd.dirty) ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (io_bus.mem_data.ready) r_state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (io_bus.mem_data.ready) r_state <= COMPARE_TAG;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
